// File: rtl/shim_integ_thresh_mon_pkg.sv
// ============================================================================
// shim_integ_thresh_mon_pkg : shared types, defaults and helpers for the
// windowed threshold monitor.                                  Rev 1.0
// ============================================================================
`default_nettype none

package shim_integ_thresh_mon_pkg;

   localparam int c_term_w         = 17;
   localparam int c_mag_w          = 15;
   localparam int c_acc_w_def      = 48;
   localparam int c_min_window_def = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   // |x| folded into 15 bits; the one unrepresentable magnitude saturates.
   function automatic logic [c_mag_w-1:0] abs_sat(input logic signed [15:0] x);
      if (x == 16'sh8000)
         return 15'h7FFF;
      return x[15] ? 15'(-x) : x[14:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/shim_integ_thresh_mon_acc_ch.sv
// ============================================================================
// shim_integ_thresh_mon_acc_ch : one channel's signed window accumulator.
// Rev 1.0
// ============================================================================
`default_nettype none

module shim_integ_thresh_mon_acc_ch
   import shim_integ_thresh_mon_pkg::*;
#(
   parameter int ACC_W = c_acc_w_def
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       add_en,
   input  logic signed [c_term_w-1:0] term,
   input  logic                       clr,
   output logic signed [ACC_W-1:0]    acc_next
);

   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_term_ext;

   assign w_term_ext = {{(ACC_W-c_term_w){term[c_term_w-1]}}, term};
   // acc_next includes a sample arriving in the same cycle as clr, so the
   // window-final value sees the last sample even though r_acc is zeroed.
   assign acc_next   = add_en ? (r_acc + w_term_ext) : r_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_acc <= '0;
      else if (clr)
         r_acc <= '0;
      else if (add_en)
         r_acc <= acc_next;
   end

endmodule

`default_nettype wire

// File: rtl/shim_integ_thresh_mon.sv
// ============================================================================
// shim_integ_thresh_mon : per-channel (|sample| - threshold) integrator with
// sticky over-threshold fault flags evaluated at each window end.  Rev 1.0
// ============================================================================
`default_nettype none

module shim_integ_thresh_mon
   import shim_integ_thresh_mon_pkg::*;
#(
   parameter  int CHANNELS   = 8,
   parameter  int ACC_W      = c_acc_w_def,
   parameter  int MIN_WINDOW = c_min_window_def,
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                integ_en,
   input  logic [14:0]         integ_thresh_avg,
   input  logic [31:0]         integ_window,
   input  logic signed [15:0]  din,
   input  logic [CH_W-1:0]     din_ch,
   input  logic                din_valid,
   output logic                running,
   output logic                window_done,
   output logic                over_thresh,
   output logic [CHANNELS-1:0] over_thresh_ch,
   output logic                cfg_err
);

   state_t                     r_state;
   logic [14:0]                r_thr;
   logic [31:0]                r_win_m1;
   logic [31:0]                r_wcnt;

   logic [c_mag_w-1:0]         w_mag;
   logic signed [c_term_w-1:0] w_term;
   logic                       w_ch_ok;
   logic                       w_last;
   logic                       w_clr;
   logic [CHANNELS-1:0]        w_add_en;
   logic [CHANNELS-1:0]        w_pos;
   logic signed [ACC_W-1:0]    w_acc_next [CHANNELS];

   assign w_mag   = abs_sat(din);
   assign w_term  = $signed({2'b00, w_mag}) - $signed({2'b00, r_thr});
   assign w_ch_ok = ({{(32-CH_W){1'b0}}, din_ch} < 32'(CHANNELS));
   assign w_last  = (r_state == ST_RUN) && (r_wcnt == 32'd0);
   // Accumulators sit at zero in IDLE, reset on RUN exit and at every window end; FAULT holds them.
   assign w_clr   = (r_state == ST_IDLE) || ((r_state == ST_RUN) && (!integ_en || w_last));

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign w_add_en[gi] = (r_state == ST_RUN) && din_valid && w_ch_ok
                            && (din_ch == CH_W'(gi));
      assign w_pos[gi]    = (w_acc_next[gi] > 0);

      shim_integ_thresh_mon_acc_ch #(
         .ACC_W    (ACC_W)
      ) u_acc (
         .clk      (clk),
         .rst      (rst),
         .add_en   (w_add_en[gi]),
         .term     (w_term),
         .clr      (w_clr),
         .acc_next (w_acc_next[gi])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_thr          <= '0;
         r_win_m1       <= '0;
         r_wcnt         <= '0;
         running        <= 1'b0;
         window_done    <= 1'b0;
         over_thresh    <= 1'b0;
         over_thresh_ch <= '0;
         cfg_err        <= 1'b0;
      end else begin
         window_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!integ_en) begin
                  cfg_err <= 1'b0;
               end else if (integ_window >= 32'(MIN_WINDOW)) begin
                  r_state  <= ST_RUN;
                  running  <= 1'b1;
                  r_thr    <= integ_thresh_avg;
                  r_win_m1 <= integ_window - 32'd1;
                  r_wcnt   <= integ_window - 32'd1;
               end else begin
                  cfg_err <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!integ_en) begin
                  r_state <= ST_IDLE;
                  running <= 1'b0;
               end else if (w_last) begin
                  window_done    <= 1'b1;
                  over_thresh_ch <= over_thresh_ch | w_pos;
                  r_wcnt         <= r_win_m1;
                  if (|w_pos) begin
                     r_state     <= ST_FAULT;
                     running     <= 1'b0;
                     over_thresh <= 1'b1;
                  end
               end else begin
                  r_wcnt <= r_wcnt - 32'd1;
               end
            end
            ST_FAULT: begin
               if (!integ_en) begin
                  r_state        <= ST_IDLE;
                  over_thresh    <= 1'b0;
                  over_thresh_ch <= '0;
                  cfg_err        <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_shim_integ_thresh_mon.sv
// ============================================================================
// tb_shim_integ_thresh_mon : scoreboard bench for the threshold monitor.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_shim_integ_thresh_mon;

   logic               clk = 1'b0;
   logic               rst;
   logic               integ_en;
   logic [14:0]        integ_thresh_avg;
   logic [31:0]        integ_window;
   logic signed [15:0] din;
   logic [2:0]         din_ch;
   logic               din_valid;
   logic               running;
   logic               window_done;
   logic               over_thresh;
   logic [7:0]         over_thresh_ch;
   logic               cfg_err;

   typedef struct packed {
      logic [7:0] ch;
      logic       ot;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   shim_integ_thresh_mon dut (
      .clk              (clk),
      .rst              (rst),
      .integ_en         (integ_en),
      .integ_thresh_avg (integ_thresh_avg),
      .integ_window     (integ_window),
      .din              (din),
      .din_ch           (din_ch),
      .din_valid        (din_valid),
      .running          (running),
      .window_done      (window_done),
      .over_thresh      (over_thresh),
      .over_thresh_ch   (over_thresh_ch),
      .cfg_err          (cfg_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic [2:0] ch, input logic signed [15:0] d);
      din_valid = v;
      din_ch    = ch;
      din       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [31:0] win, input logic [14:0] thr);
      integ_window     = win;
      integ_thresh_avg = thr;
      integ_en         = 1'b1;
      step(1'b0, 3'd0, 16'sd0);
   endtask

   task automatic stop();
      integ_en = 1'b0;
      step(1'b0, 3'd0, 16'sd0);
   endtask

   always @(negedge clk) begin
      if (!rst && window_done) begin
         if (sb.size() == 0) begin
            chk("wd_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wd_ch", {24'd0, over_thresh_ch}, {24'd0, e.ch});
            chk("wd_ot", {31'd0, over_thresh}, {31'd0, e.ot});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; integ_en = 1'b0; integ_thresh_avg = '0; integ_window = '0;
      din = '0; din_ch = '0; din_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_running", running, 0);
      chk("rst_wd", window_done, 0);
      chk("rst_ot", over_thresh, 0);
      chk("rst_otch", over_thresh_ch, 0);
      chk("rst_cfg", cfg_err, 0);
      rst = 1'b0;
      step(1'b0, 3'd0, 16'sd0);

      // ch0 well above threshold: fault on the first window end
      start(32'd8, 15'd100);
      chk("s1_running", running, 1);
      sb.push_back('{ch: 8'h01, ot: 1'b1});
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("s1_wd_early", window_done, 0);
         step(1'b1, 3'd0, (i % 2) ? -16'sd150 : 16'sd150);
      end
      chk("s1_wd", window_done, 1);
      chk("s1_fault_run", running, 0);
      chk("s1_ot", over_thresh, 1);
      repeat (10) step(1'b1, 3'd0, 16'sd150);
      chk("s1_hold", over_thresh_ch, 8'h01);
      stop();
      chk("s1_clr_ot", over_thresh, 0);
      chk("s1_clr_otch", over_thresh_ch, 0);

      // average exactly at threshold: two clean back-to-back windows
      start(32'd8, 15'd100);
      sb.push_back('{ch: 8'h00, ot: 1'b0});
      sb.push_back('{ch: 8'h00, ot: 1'b0});
      for (int i = 0; i < 16; i++) step(1'b1, 3'd2, (i % 2) ? 16'sd0 : 16'sd200);
      chk("s2_running", running, 1);
      chk("s2_ot", over_thresh, 0);
      stop();

      // most negative sample saturates to the threshold
      start(32'd4, 15'h7FFF);
      sb.push_back('{ch: 8'h00, ot: 1'b0});
      for (int i = 0; i < 4; i++) step(1'b1, 3'd7, -16'sd32768);
      chk("s3_otch", over_thresh_ch, 0);
      stop();

      // window too short
      integ_window = 32'd3; integ_thresh_avg = 15'd0; integ_en = 1'b1;
      step(1'b0, 3'd0, 16'sd0);
      chk("s4_cfg", cfg_err, 1);
      chk("s4_running", running, 0);
      step(1'b1, 3'd0, 16'sd1000);
      chk("s4_cfg_hold", cfg_err, 1);
      stop();
      chk("s4_cfg_clr", cfg_err, 0);

      // sample in the last window cycle tips ch1 from -1 to +49
      start(32'd4, 15'd50);
      sb.push_back('{ch: 8'h02, ot: 1'b1});
      step(1'b1, 3'd1, 16'sd49);
      repeat (2) step(1'b0, 3'd1, 16'sd0);
      step(1'b1, 3'd1, 16'sd100);
      chk("s5a_ot", over_thresh, 1);
      stop();

      // same sample one cycle late lands in the following window
      start(32'd4, 15'd50);
      sb.push_back('{ch: 8'h00, ot: 1'b0});
      sb.push_back('{ch: 8'h02, ot: 1'b1});
      step(1'b1, 3'd1, 16'sd49);
      repeat (3) step(1'b0, 3'd1, 16'sd0);
      step(1'b1, 3'd1, 16'sd100);
      repeat (3) step(1'b0, 3'd1, 16'sd0);
      chk("s5b_otch", over_thresh_ch, 8'h02);
      stop();

      // config changes mid-RUN are ignored
      start(32'd4, 15'd100);
      integ_thresh_avg = 15'd0;
      integ_window     = 32'd2;
      sb.push_back('{ch: 8'h00, ot: 1'b0});
      sb.push_back('{ch: 8'h08, ot: 1'b1});
      for (int i = 0; i < 4; i++) step(1'b1, 3'd3, 16'sd100);
      for (int i = 0; i < 4; i++) step(1'b1, 3'd3, 16'sd150);
      chk("s6_ot", over_thresh, 1);
      stop();
      chk("s6_clr_ot", over_thresh, 0);
      chk("s6_clr_otch", over_thresh_ch, 0);
      chk("s6_running", running, 0);

      // enable dropped mid-window discards the partial sum
      start(32'd8, 15'd100);
      for (int i = 0; i < 3; i++) step(1'b1, 3'd4, 16'sd1000);
      stop();
      chk("s7_running", running, 0);
      start(32'd8, 15'd100);
      sb.push_back('{ch: 8'h00, ot: 1'b0});
      for (int i = 0; i < 8; i++) step(1'b1, 3'd4, 16'sd0);
      chk("s7_otch", over_thresh_ch, 0);
      stop();

      // asynchronous reset mid-window
      start(32'd4, 15'd0);
      repeat (2) step(1'b1, 3'd5, 16'sd500);
      #2 rst = 1'b1;
      #1;
      chk("s8_running", running, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      integ_en = 1'b0;
      repeat (6) step(1'b1, 3'd5, 16'sd500);
      chk("s8_otch", over_thresh_ch, 0);
      chk("s8_ot", over_thresh, 0);

      repeat (2) step(1'b0, 3'd0, 16'sd0);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
